fp_addsub_sequencer: RTL and testbench

Multi-cycle controller that sequences single-precision floating-point add/subtract through the exponent compare, mantissa align, mantissa add and normalize steps. It is built around one shared, registered datapath. Operands enter on a valid/ready handshake and the packed result leaves on a valid/ready handshake. It replaces the combinational stage chain wherever an area-lean, iterative adder is wanted ahead of the future rounding stage.

---
 rtl/fp_addsub_sequencer_if.sv | 25 ++
 rtl/fp_addsub_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_sequencer_if.sv
// Operand request / result handshake bundle for fp_addsub_sequencer.
// The slave modport is the sequencer side; the master modport is the requester/consumer side.
interface fp_addsub_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid_in;
    logic                  in_ready_out;
    logic [DATA_WIDTH-1:0] floating1_in;
    logic [DATA_WIDTH-1:0] floating2_in;
    logic                  opcode_in;
    logic                  out_valid_out;
    logic                  out_ready_in;
    logic [DATA_WIDTH-1:0] floating_result_out;
    logic                  busy_out;

    modport slave (
        input  in_valid_in, floating1_in, floating2_in, opcode_in, out_ready_in,
        output in_ready_out, out_valid_out, floating_result_out, busy_out
    );

    modport master (
        output in_valid_in, floating1_in, floating2_in, opcode_in, out_ready_in,
        input  in_ready_out, out_valid_out, floating_result_out, busy_out
    );
endinterface

// File: rtl/fp_addsub_sequencer.sv
// Iterative single-precision add/subtract: one shared datapath stepped through CMP, ALIGN, ADD, NORM.
// Define FP_SPECIAL_CASE_EN to short-circuit Inf/NaN operands straight from CMP to DONE.
module fp_addsub_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    fp_addsub_sequencer_if.slave     bus
);
    localparam int MW = MENT_WIDTH + 1;
    localparam int SW = MENT_WIDTH + 2;
    localparam int EW = EXPO_WIDTH + 1;
    localparam logic [EW-1:0] EXP_ONES  = {1'b0, {EXPO_WIDTH{1'b1}}};
    localparam logic [EW-1:0] SHIFT_MAX = EW'(MENT_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] a_r, b_r, result_r;
    logic                  op_r;
    logic                  sign_r, sub_r;
    logic [EW-1:0]         exp_r, shift_r;
    logic [MW-1:0]         mx_r, my_r;
    logic [SW-1:0]         sum_r;

    function automatic logic [DATA_WIDTH-1:0] pack(input logic s,
                                                    input logic [EXPO_WIDTH-1:0] e,
                                                    input logic [MENT_WIDTH-1:0] m);
        return {s, e, m};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_inf(input logic s);
        return {s, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
    endfunction

    // Operand decode: a zero exponent field means the value is zero
    logic [EXPO_WIDTH-1:0] ea, eb, ex, ey;
    logic [MW-1:0]         ma, mb, mx, my;
    logic                  sa, sb, sx, sy, a_ge_b, far;
    logic [EW-1:0]         diff;

    assign ea     = a_r[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign eb     = b_r[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign ma     = (ea == '0) ? '0 : {1'b1, a_r[MENT_WIDTH-1:0]};
    assign mb     = (eb == '0) ? '0 : {1'b1, b_r[MENT_WIDTH-1:0]};
    assign sa     = a_r[DATA_WIDTH-1];
    assign sb     = b_r[DATA_WIDTH-1] ^ op_r;
    assign a_ge_b = {ea, ma} >= {eb, mb};
    assign ex     = a_ge_b ? ea : eb;
    assign ey     = a_ge_b ? eb : ea;
    assign mx     = a_ge_b ? ma : mb;
    assign my     = a_ge_b ? mb : ma;
    assign sx     = a_ge_b ? sa : sb;
    assign sy     = a_ge_b ? sb : sa;
    assign diff   = {1'b0, ex} - {1'b0, ey};
    assign far    = diff > SHIFT_MAX;

    logic          sum_zero, carry, lead;
    logic [EW-1:0] exp_inc, exp_dec;

    assign sum_zero = (sum_r == '0);
    assign carry    = sum_r[SW-1];
    assign lead     = sum_r[MENT_WIDTH];
    assign exp_inc  = exp_r + EW'(1);
    assign exp_dec  = exp_r - EW'(1);

    logic special;
`ifdef FP_SPECIAL_CASE_EN
    logic                  a_inf, b_inf, a_nan, b_nan;
    logic [DATA_WIDTH-1:0] special_result;

    assign a_inf   = (ea == {EXPO_WIDTH{1'b1}}) && (a_r[MENT_WIDTH-1:0] == '0);
    assign b_inf   = (eb == {EXPO_WIDTH{1'b1}}) && (b_r[MENT_WIDTH-1:0] == '0);
    assign a_nan   = (ea == {EXPO_WIDTH{1'b1}}) && (a_r[MENT_WIDTH-1:0] != '0);
    assign b_nan   = (eb == {EXPO_WIDTH{1'b1}}) && (b_r[MENT_WIDTH-1:0] != '0);
    assign special = a_inf || b_inf || a_nan || b_nan;

    always_comb begin
        special_result = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            special_result = {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};
        else if (a_inf)
            special_result = sat_inf(sa);
        else
            special_result = sat_inf(sb);
    end
`else
    assign special = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.in_ready_out  = 1'b0;
        bus.out_valid_out = 1'b0;
        bus.busy_out      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready_out = 1'b1;
                bus.busy_out     = 1'b0;
                if (bus.in_valid_in) state_next = CMP;
            end
            CMP:   state_next = special ? DONE : ALIGN;
            ALIGN: if (shift_r == '0) state_next = ADD;
            ADD:   state_next = NORM;
            NORM:  if (sum_zero || carry || lead || exp_dec == '0) state_next = DONE;
            DONE: begin
                bus.out_valid_out = 1'b1;
                if (bus.out_ready_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            sign_r   <= 1'b0;
            sub_r    <= 1'b0;
            exp_r    <= '0;
            shift_r  <= '0;
            mx_r     <= '0;
            my_r     <= '0;
            sum_r    <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid_in) begin
                    a_r  <= bus.floating1_in;
                    b_r  <= bus.floating2_in;
                    op_r <= bus.opcode_in;
                end
                CMP: begin
`ifdef FP_SPECIAL_CASE_EN
                    if (special) result_r <= special_result;
`endif
                    sign_r <= sx;
                    sub_r  <= sx ^ sy;
                    exp_r  <= {1'b0, ex};
                    mx_r   <= mx;
                    // Y too small to reach any kept bit: drop it and skip alignment
                    my_r    <= far ? '0 : my;
                    shift_r <= far ? '0 : diff;
                end
                ALIGN: if (shift_r != '0) begin
                    my_r    <= my_r >> 1;
                    shift_r <= shift_r - EW'(1);
                end
                ADD: sum_r <= sub_r ? ({1'b0, mx_r} - {1'b0, my_r}) : ({1'b0, mx_r} + {1'b0, my_r});
                NORM: begin
                    if (sum_zero)
                        result_r <= '0;
                    else if (carry)
                        result_r <= (exp_inc >= EXP_ONES) ? sat_inf(sign_r)
                                  : pack(sign_r, exp_inc[EXPO_WIDTH-1:0], sum_r[MENT_WIDTH:1]);
                    else if (lead)
                        result_r <= pack(sign_r, exp_r[EXPO_WIDTH-1:0], sum_r[MENT_WIDTH-1:0]);
                    else if (exp_dec == '0)
                        result_r <= pack(sign_r, '0, '0);
                    else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.floating_result_out = result_r;
endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Self-checking bench for fp_addsub_sequencer: directed vector table, handshake corner sequences,
// and randomized operands compared against an arithmetic reference model.
module tb_fp_addsub_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_addsub_sequencer_if #(.DATA_WIDTH(32)) bus();

    fp_addsub_sequencer #(
        .DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          op;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: value-level arithmetic with truncating alignment and leading-zero normalization
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit op,
                                  output logic [31:0] res, output int lat);
        int ea, eb, ma, mb, ex, ey, mx, my, d, s, p, lz, n;
        bit sa, sb, sx, sy;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : (int'(a[22:0]) + (1 << 23));
        mb = (eb == 0) ? 0 : (int'(b[22:0]) + (1 << 23));
        sa = a[31];
        sb = b[31] ^ op;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
        end else begin
            ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
        end
        d = ex - ey;
        if (d > 24) begin
            my = 0;
            d  = 0;
        end else begin
            my = my >> d;
        end
        s = (sx != sy) ? (mx - my) : (mx + my);
        if (s == 0) begin
            res = 32'h0;
            n   = 1;
        end else if (s >= (1 << 24)) begin
            n = 1;
            if (ex + 1 >= 255) res = {sx, 8'hFF, 23'h0};
            else               res = {sx, 8'(ex + 1), 23'(s >> 1)};
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (s >= (1 << i)) p = i;
            lz = 23 - p;
            if (ex > lz) begin
                res = {sx, 8'(ex - lz), 23'(s << lz)};
                n   = lz + 1;
            end else begin
                res = {sx, 31'h0};
                n   = ex;
            end
        end
        lat = d + n + 3;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit op, input int hold,
                          output logic [31:0] res, output int lat);
        int cnt;
        bit got;
        check("in_ready_idle", {31'h0, bus.in_ready_out}, 32'h1);
        bus.floating1_in = a;
        bus.floating2_in = b;
        bus.opcode_in    = op;
        bus.in_valid_in  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_in  = 1'b0;
        bus.floating1_in = $urandom;
        bus.floating2_in = $urandom;
        bus.opcode_in    = ~op;
        cnt = 0;
        got = 0;
        while (!got && cnt < 200) begin
            if (bus.out_valid_out) got = 1;
            else begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout: out_valid never rose within %0d cycles for %08h op %0d %08h", cnt, a, op, b);
            res = 32'hxxxxxxxx;
            lat = -1;
        end else begin
            res = bus.floating_result_out;
            lat = cnt;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_valid", {31'h0, bus.out_valid_out}, 32'h1);
                check("hold_result", bus.floating_result_out, res);
                check("hold_in_ready", {31'h0, bus.in_ready_out}, 32'h0);
            end
            bus.out_ready_in = 1'b1;
            @(posedge clk); #1;
            bus.out_ready_in = 1'b0;
            check("valid_drop", {31'h0, bus.out_valid_out}, 32'h0);
            check("busy_drop", {31'h0, bus.busy_out}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] res, exp_res, a, b;
        int lat, exp_lat, e1, e2;
        bit op, seen;

        rst_n            = 1'b0;
        bus.in_valid_in  = 1'b0;
        bus.floating1_in = '0;
        bus.floating2_in = '0;
        bus.opcode_in    = 1'b0;
        bus.out_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, bus.in_ready_out}, 32'h1);
        check("rst_out_valid", {31'h0, bus.out_valid_out}, 32'h0);
        check("rst_busy", {31'h0, bus.busy_out}, 32'h0);
        check("rst_result", bus.floating_result_out, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4};
        vecs[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4};
        vecs[2] = '{32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 6};
        vecs[3] = '{32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 6};
        vecs[4] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 28};
        vecs[5] = '{32'h4C000000, 32'h3F800000, 1'b0, 32'h4C000000, 4};
        vecs[6] = '{32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4};
        vecs[7] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4};
        vecs[8] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4};
        vecs[9] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 27};

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, i % 3, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Back-pressure: result held for 10 cycles, then exactly one handshake
        run_op(32'h3FC00000, 32'h3E800000, 1'b0, 10, res, lat);
        check("bp_result", res, 32'h3FE00000);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid_out) seen = 1;
        end
        check("bp_single_handshake", {31'h0, seen}, 32'h0);

        // Abort in the middle of a long alignment
        bus.floating1_in = 32'h4B800000;
        bus.floating2_in = 32'h3F800000;
        bus.opcode_in    = 1'b0;
        bus.in_valid_in  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_abort_busy", {31'h0, bus.busy_out}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", {31'h0, bus.in_ready_out}, 32'h1);
        check("abort_out_valid", {31'h0, bus.out_valid_out}, 32'h0);
        check("abort_busy", {31'h0, bus.busy_out}, 32'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid_out || bus.busy_out) seen = 1;
        end
        check("abort_no_result", {31'h0, seen}, 32'h0);
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, res, lat);
        check("post_abort_result", res, 32'h40000000);
        check("post_abort_latency", lat, 4);

        // Randomized operands against the reference model
        for (int k = 0; k < 150; k++) begin
            e1 = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 254));
            if ($urandom_range(0, 7) == 0) e2 = int'($urandom_range(0, 254));
            else                           e2 = e1 + int'($urandom_range(0, 52)) - 26;
            if (e2 < 0)   e2 = 0;
            if (e2 > 254) e2 = 254;
            a  = {1'($urandom), 8'(e1), 23'($urandom)};
            b  = {1'($urandom), 8'(e2), 23'($urandom)};
            if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
            op = 1'($urandom);
            model(a, b, op, exp_res, exp_lat);
            run_op(a, b, op, int'($urandom_range(0, 3)), res, lat);
            check($sformatf("rand%0d_result %08h op%0d %08h", k, a, op, b), res, exp_res);
            check($sformatf("rand%0d_latency", k), lat, exp_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
